// File: rtl/clk_div_bank_if.sv
// Control and status bundle for clk_div_bank: run enables, phase sync, divisor
// writes, and the per-channel divided clocks, ticks and config status.
interface clk_div_bank_if #(
  parameter int NCH = 3,
  parameter int CW  = 9,
  parameter int CHW = 2
);
  logic [NCH-1:0] en;
  logic           sync;
  logic           cfg_wr;
  logic [CHW-1:0] cfg_ch;
  logic [CW-1:0]  cfg_div;
  logic           cfg_err;
  logic [NCH-1:0] cfg_pend;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;

  modport master (
    output en, sync, cfg_wr, cfg_ch, cfg_div,
    input  cfg_err, cfg_pend, clk_out, tick
  );

  modport slave (
    input  en, sync, cfg_wr, cfg_ch, cfg_div,
    output cfg_err, cfg_pend, clk_out, tick
  );
endinterface

// File: rtl/clk_div_bank.sv
// Bank of NCH integer clock dividers with registered level and tick outputs; a channel
// ticks on the first edge that samples its enable, and new divisors land only at period boundaries.
module clk_div_bank #(
  parameter int                  NCH     = 3,
  parameter int                  CW      = 9,
  parameter int                  CHW     = 2,
  parameter logic [NCH*CW-1:0]   DEF_DIV = {9'd288, 9'd32, 9'd2}
) (
  input  logic           i_mainclk,
  input  logic           i_reset,
  clk_div_bank_if.slave  bus
);

  localparam logic [CHW:0] NCH_W = (CHW+1)'(NCH);

  logic [CW-1:0]  r_cnt [NCH];
  logic [CW-1:0]  r_act [NCH];
  logic [CW-1:0]  r_shd [NCH];
  logic [NCH-1:0] r_run;
  logic [NCH-1:0] r_pend;
  logic [NCH-1:0] r_clk;
  logic [NCH-1:0] r_tick;
  logic           r_err;

  logic           w_wr_ok;
  logic [NCH-1:0] w_bound;
  logic [NCH-1:0] w_wr_hit;
  logic [NCH-1:0] w_clk_nxt;

  assign w_wr_ok = bus.cfg_wr && (bus.cfg_div >= CW'(2)) && ({1'b0, bus.cfg_ch} < NCH_W);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [CW-1:0] w_hi;
    logic [CW-1:0] w_inc;

    // High phase is the ceiling half, so odd divisors stay high one extra cycle.
    assign w_hi         = r_act[g] - (r_act[g] >> 1);
    assign w_inc        = r_cnt[g] + CW'(1);
    assign w_clk_nxt[g] = w_inc < w_hi;
    assign w_bound[g]   = !r_run[g] || bus.sync || (r_cnt[g] == r_act[g] - CW'(1));
    assign w_wr_hit[g]  = w_wr_ok && (bus.cfg_ch == CHW'(g));
  end

  always_ff @(posedge i_mainclk or negedge i_reset) begin
    if (!i_reset) begin
      r_run  <= '0;
      r_pend <= '0;
      r_clk  <= '0;
      r_tick <= '0;
      r_err  <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        r_cnt[i] <= '0;
        r_act[i] <= DEF_DIV[i*CW +: CW];
        r_shd[i] <= DEF_DIV[i*CW +: CW];
      end
    end else begin
      r_err <= bus.cfg_wr && !w_wr_ok;
      for (int i = 0; i < NCH; i++) begin
        if (!bus.en[i]) begin
          r_run[i]  <= 1'b0;
          r_cnt[i]  <= '0;
          r_clk[i]  <= 1'b0;
          r_tick[i] <= 1'b0;
        end else if (w_bound[i]) begin
          r_run[i]  <= 1'b1;
          r_cnt[i]  <= '0;
          r_clk[i]  <= 1'b1;
          r_tick[i] <= 1'b1;
          r_act[i]  <= r_shd[i];
        end else begin
          r_cnt[i]  <= w_inc_sel(i);
          r_clk[i]  <= w_clk_nxt[i];
          r_tick[i] <= 1'b0;
        end

        // A write on the boundary edge wins over the clear, so it is applied one period later.
        if (w_wr_hit[i]) begin
          r_shd[i]  <= bus.cfg_div;
          r_pend[i] <= 1'b1;
        end else if (bus.en[i] && w_bound[i]) begin
          r_pend[i] <= 1'b0;
        end
      end
    end
  end

  function automatic logic [CW-1:0] w_inc_sel(input int idx);
    return r_cnt[idx] + CW'(1);
  endfunction

  assign bus.clk_out  = r_clk;
  assign bus.tick     = r_tick;
  assign bus.cfg_pend = r_pend;
  assign bus.cfg_err  = r_err;

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: constant vector table, directed corner sequences,
// and randomized traffic against a phase-counting reference model.
module tb_clk_div_bank;
  localparam int NCH = 3;
  localparam int CW  = 9;
  localparam int CHW = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  clk_div_bank_if #(.NCH(NCH), .CW(CW), .CHW(CHW)) bus ();

  clk_div_bank #(
    .NCH(NCH), .CW(CW), .CHW(CHW), .DEF_DIV({9'd288, 9'd32, 9'd2})
  ) dut (
    .i_mainclk (clk),
    .i_reset   (rst_n),
    .bus       (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: per channel, whether it runs, its phase within the period,
  // the period length in use, the waiting divisor and whether one is waiting.
  int m_run  [NCH];
  int m_ph   [NCH];
  int m_n    [NCH];
  int m_shd  [NCH];
  int m_pend [NCH];
  int m_err;

  typedef struct {
    logic [2:0] en;
    logic       sync;
    logic       wr;
    logic [1:0] ch;
    logic [8:0] div;
    logic [2:0] e_clk;
    logic [2:0] e_tick;
    logic [2:0] e_pend;
    logic       e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic int def_div(input int c);
    return (c == 0) ? 2 : (c == 1) ? 32 : 288;
  endfunction

  function automatic logic [NCH-1:0] exp_clk();
    logic [NCH-1:0] r;
    r = '0;
    for (int c = 0; c < NCH; c++)
      r[c] = (m_run[c] != 0) && (m_ph[c] < (m_n[c] + 1) / 2);
    return r;
  endfunction

  function automatic logic [NCH-1:0] exp_tick();
    logic [NCH-1:0] r;
    r = '0;
    for (int c = 0; c < NCH; c++)
      r[c] = (m_run[c] != 0) && (m_ph[c] == 0);
    return r;
  endfunction

  function automatic logic [NCH-1:0] exp_pend();
    logic [NCH-1:0] r;
    r = '0;
    for (int c = 0; c < NCH; c++)
      r[c] = (m_pend[c] != 0);
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_run[c]  = 0;
      m_ph[c]   = 0;
      m_n[c]    = def_div(c);
      m_shd[c]  = def_div(c);
      m_pend[c] = 0;
    end
    m_err = 0;
  endtask

  task automatic model_edge();
    bit ok;
    int ch;
    int dv;
    ch = int'(bus.cfg_ch);
    dv = int'(bus.cfg_div);
    ok = bus.cfg_wr && (dv >= 2) && (ch < NCH);
    for (int c = 0; c < NCH; c++) begin
      if (!bus.en[c]) begin
        m_run[c] = 0;
        m_ph[c]  = 0;
      end else if (m_run[c] == 0 || bus.sync || m_ph[c] == m_n[c] - 1) begin
        m_run[c]  = 1;
        m_ph[c]   = 0;
        m_n[c]    = m_shd[c];
        m_pend[c] = 0;
      end else begin
        m_ph[c] = m_ph[c] + 1;
      end
    end
    if (ok) begin
      m_shd[ch]  = dv;
      m_pend[ch] = 1;
    end
    m_err = (bus.cfg_wr && !ok) ? 1 : 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    check("clk_out", bus.clk_out,  exp_clk());
    check("tick",    bus.tick,     exp_tick());
    check("cfg_pend", bus.cfg_pend, exp_pend());
    check("cfg_err", bus.cfg_err,  m_err[0]);
  endtask

  // Advance one clock; callers drive inputs between calls (1ns after the edge).
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic enter_reset();
    #3;
    rst_n = 1'b0;
    #1;
    check("areset_clk",  bus.clk_out,  0);
    check("areset_tick", bus.tick,     0);
    check("areset_pend", bus.cfg_pend, 0);
    check("areset_err",  bus.cfg_err,  0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.sync    = 1'b0;
    bus.cfg_wr  = 1'b0;
    bus.cfg_ch  = '0;
    bus.cfg_div = '0;
  endtask

  task automatic add(input logic [2:0] en, input logic wr, input logic [1:0] ch, input logic [8:0] dv,
                     input logic [2:0] ec, input logic [2:0] et, input logic [2:0] ep, input logic ee);
    vec_t v;
    v.en = en; v.sync = 1'b0; v.wr = wr; v.ch = ch; v.div = dv;
    v.e_clk = ec; v.e_tick = et; v.e_pend = ep; v.e_err = ee;
    tbl.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hi1, hi2, t0, t2, hi, tk;

    bus.en = '0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_clk",  bus.clk_out,  0);
    check("rst_tick", bus.tick,     0);
    check("rst_pend", bus.cfg_pend, 0);
    check("rst_err",  bus.cfg_err,  0);

    // Defaults after release: all three channels tick on the first edge.
    bus.en = 3'b111;
    rst_n  = 1'b1;
    step();
    check("first_tick", bus.tick, 3'b111);
    hi1 = 1; hi2 = 1; t0 = 1; t2 = 0;
    for (int k = 1; k < 576; k++) begin
      step();
      hi1 += int'(bus.clk_out[1]);
      hi2 += int'(bus.clk_out[2]);
      t0  += int'(bus.tick[0]);
      if (bus.tick[2]) begin
        t2++;
        check("ch2_period", k, 288);
      end
    end
    check("ch2_tick_cnt", t2, 1);
    check("ch2_high", hi2, 288);
    check("ch1_high", hi1, 288);
    check("ch0_ticks", t0, 288);

    // Mid-period divisor write on ch0.
    step();
    bus.cfg_wr = 1'b1; bus.cfg_ch = 2'd0; bus.cfg_div = 9'd5;
    step();
    idle_inputs();
    check("wr5_pend", bus.cfg_pend[0], 1);
    check("wr5_notick", bus.tick[0], 0);
    step();
    check("wr5_apply_tick", bus.tick[0], 1);
    check("wr5_apply_pend", bus.cfg_pend[0], 0);
    hi = 0; tk = 0;
    repeat (10) begin
      step();
      hi += int'(bus.clk_out[0]);
      tk += int'(bus.tick[0]);
    end
    check("div5_ticks", tk, 2);
    check("div5_high", hi, 6);

    // Vector table from a clean reset with all channels idle.
    enter_reset();
    bus.en = 3'b000;
    rst_n  = 1'b1;
    add(3'b000, 0, 2'd0, 9'd0,   3'b000, 3'b000, 3'b000, 0);
    add(3'b000, 1, 2'd0, 9'd5,   3'b000, 3'b000, 3'b001, 0);
    add(3'b000, 1, 2'd0, 9'd1,   3'b000, 3'b000, 3'b001, 1);
    add(3'b000, 0, 2'd0, 9'd0,   3'b000, 3'b000, 3'b001, 0);
    add(3'b000, 1, 2'd3, 9'd7,   3'b000, 3'b000, 3'b001, 1);
    add(3'b000, 1, 2'd2, 9'd0,   3'b000, 3'b000, 3'b001, 1);
    add(3'b000, 1, 2'd1, 9'd3,   3'b000, 3'b000, 3'b011, 0);
    add(3'b000, 1, 2'd1, 9'd4,   3'b000, 3'b000, 3'b011, 0);
    add(3'b001, 0, 2'd0, 9'd0,   3'b001, 3'b001, 3'b010, 0);
    add(3'b001, 0, 2'd0, 9'd0,   3'b001, 3'b000, 3'b010, 0);
    add(3'b001, 0, 2'd0, 9'd0,   3'b001, 3'b000, 3'b010, 0);
    add(3'b001, 0, 2'd0, 9'd0,   3'b000, 3'b000, 3'b010, 0);
    add(3'b001, 0, 2'd0, 9'd0,   3'b000, 3'b000, 3'b010, 0);
    add(3'b001, 0, 2'd0, 9'd0,   3'b001, 3'b001, 3'b010, 0);
    add(3'b011, 0, 2'd0, 9'd0,   3'b011, 3'b010, 3'b000, 0);
    add(3'b011, 0, 2'd0, 9'd0,   3'b011, 3'b000, 3'b000, 0);
    add(3'b011, 0, 2'd0, 9'd0,   3'b000, 3'b000, 3'b000, 0);
    add(3'b011, 0, 2'd0, 9'd0,   3'b000, 3'b000, 3'b000, 0);
    add(3'b011, 0, 2'd0, 9'd0,   3'b011, 3'b011, 3'b000, 0);
    foreach (tbl[i]) begin
      bus.en = tbl[i].en; bus.sync = tbl[i].sync; bus.cfg_wr = tbl[i].wr;
      bus.cfg_ch = tbl[i].ch; bus.cfg_div = tbl[i].div;
      step();
      check($sformatf("vec%0d_clk", i),  bus.clk_out,  tbl[i].e_clk);
      check($sformatf("vec%0d_tick", i), bus.tick,     tbl[i].e_tick);
      check($sformatf("vec%0d_pend", i), bus.cfg_pend, tbl[i].e_pend);
      check($sformatf("vec%0d_err", i),  bus.cfg_err,  tbl[i].e_err);
    end
    idle_inputs();

    // Sync at ch2 phase 100, then ch1/ch2 re-coincide a full ch2 period later.
    enter_reset();
    bus.en = 3'b111;
    rst_n  = 1'b1;
    step();
    repeat (100) step();
    bus.sync = 1'b1;
    step();
    bus.sync = 1'b0;
    check("sync_tick", bus.tick, 3'b111);
    repeat (288) step();
    check("sync_recoincide", bus.tick, 3'b111);

    // Enable toggling on ch1.
    repeat (5) step();
    bus.en = 3'b101;
    step();
    check("dis_clk1",  bus.clk_out[1], 0);
    check("dis_tick1", bus.tick[1], 0);
    repeat (3) step();
    bus.en = 3'b111;
    step();
    check("reen_tick1", bus.tick[1], 1);
    hi = int'(bus.clk_out[1]);
    repeat (31) begin
      step();
      hi += int'(bus.clk_out[1]);
    end
    check("reen_high1", hi, 16);
    step();
    check("reen_next_tick1", bus.tick[1], 1);

    // Write to ch0 landing exactly on its boundary edge.
    enter_reset();
    bus.en = 3'b001;
    rst_n  = 1'b1;
    step();
    step();
    bus.cfg_wr = 1'b1; bus.cfg_ch = 2'd0; bus.cfg_div = 9'd3;
    step();
    idle_inputs();
    check("bwr_e3_tick", bus.tick[0], 1);
    check("bwr_e3_pend", bus.cfg_pend[0], 1);
    step();
    check("bwr_e4_tick", bus.tick[0], 0);
    step();
    check("bwr_e5_tick", bus.tick[0], 1);
    check("bwr_e5_pend", bus.cfg_pend[0], 0);
    step();
    check("bwr_e6_tick", bus.tick[0], 0);
    step();
    check("bwr_e7_tick", bus.tick[0], 0);
    step();
    check("bwr_e8_tick", bus.tick[0], 1);

    // Async reset mid-run with a pending shadow; defaults must return.
    bus.en = 3'b111;
    repeat (20) step();
    bus.cfg_wr = 1'b1; bus.cfg_ch = 2'd2; bus.cfg_div = 9'd7;
    step();
    idle_inputs();
    repeat (10) step();
    check("pre_rst_pend2", bus.cfg_pend[2], 1);
    enter_reset();
    rst_n = 1'b1;
    step();
    check("post_rst_tick", bus.tick, 3'b111);
    repeat (300) step();

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      idle_inputs();
      if ($urandom_range(0, 19) == 0) begin
        int b;
        b = $urandom_range(0, NCH - 1);
        bus.en[b] = ~bus.en[b];
      end
      if ($urandom_range(0, 39) == 0) bus.sync = 1'b1;
      if ($urandom_range(0, 7) == 0) begin
        bus.cfg_wr = 1'b1;
        bus.cfg_ch = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 9) == 0) bus.cfg_div = 9'($urandom_range(0, 511));
        else bus.cfg_div = 9'($urandom_range(0, 12));
      end
      step();
    end
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
